// File: rtl/alu_feeder.sv
// Command FIFO feeding an external combinational ALU, with a registered result stage.
// Optional opcode filter (000/111 dropped, counted in err_cnt) under ALU_FEEDER_ILLEGAL_FILTER_EN.
module alu_feeder #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [31:0]   in_a,
  input  logic [31:0]   in_b,
  output logic [2:0]    alu_op,
  output logic [31:0]   alu_a,
  output logic [31:0]   alu_b,
  input  logic [31:0]   alu_r,
  input  logic          alu_z,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_r,
  output logic          out_z,
  output logic [2:0]    out_op,
  output logic [CW-1:0] count
`ifdef ALU_FEEDER_ILLEGAL_FILTER_EN
  ,
  output logic [15:0]   err_cnt
`endif
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready are
  // both high; valid never depends on ready, and a held result stays stable until taken.

  logic [2:0]    op_mem [DEPTH];
  logic [31:0]   a_mem  [DEPTH];
  logic [31:0]   b_mem  [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ready_en;
  logic          accept;
  logic          do_push;
  logic          do_pop;

  assign in_ready = ready_en && (count < CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign do_pop   = (count != '0) && (!out_valid || out_ready);

`ifdef ALU_FEEDER_ILLEGAL_FILTER_EN
  logic illegal;
  assign illegal = (in_op == 3'b000) || (in_op == 3'b111);
  assign do_push = accept && !illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && illegal && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`else
  assign do_push = accept;
`endif

  always_comb begin
    alu_op = '0;
    alu_a  = '0;
    alu_b  = '0;
    if (count != '0) begin
      alu_op = op_mem[rd_ptr];
      alu_a  = a_mem[rd_ptr];
      alu_b  = b_mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      op_mem[wr_ptr] <= in_op;
      a_mem[wr_ptr]  <= in_a;
      b_mem[wr_ptr]  <= in_b;
    end
  end

  // ready_en holds in_ready low through reset and for the edge that releases it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      ready_en <= 1'b1;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_r     <= '0;
      out_z     <= 1'b0;
      out_op    <= '0;
    end else if (do_pop) begin
      out_valid <= 1'b1;
      out_r     <= alu_r;
      out_z     <= alu_z;
      out_op    <= alu_op;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_feeder.sv
// Directed bench for alu_feeder with a small combinational ALU model on the alu_* side.
// Filter checks are compiled in when ALU_FEEDER_ILLEGAL_FILTER_EN is defined.
module tb_alu_feeder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_r;
  logic        alu_z;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_r;
  logic        out_z;
  logic [2:0]  out_op;
  logic [2:0]  count;
`ifdef ALU_FEEDER_ILLEGAL_FILTER_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  alu_feeder #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_r(alu_r), .alu_z(alu_z),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_z(out_z), .out_op(out_op),
    .count(count)
`ifdef ALU_FEEDER_ILLEGAL_FILTER_EN
    , .err_cnt(err_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // downstream ALU model
  always_comb begin
    case (alu_op)
      3'b001:  alu_r = alu_a + alu_b;
      3'b010:  alu_r = alu_a & alu_b;
      3'b011:  alu_r = alu_a | alu_b;
      3'b100:  alu_r = alu_a ^ alu_b;
      3'b101:  alu_r = alu_a - alu_b;
      default: alu_r = alu_a;
    endcase
    alu_z = (alu_r == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_r", out_r, 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_alu_a_zero", alu_a, 32'd0);
    rst_n = 1'b1;
    #1;
    check("in_ready_before_edge", 32'(in_ready), 32'd0);
    tick();
    check("in_ready_after_edge", 32'(in_ready), 32'd1);

    // single op: 5 + 7
    out_ready = 1'b1;
    drive(1'b1, 3'b001, 32'd5, 32'd7);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("single_count", 32'(count), 32'd1);
    check("single_alu_a", alu_a, 32'd5);
    check("single_valid_early", 32'(out_valid), 32'd0);
    tick();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_r", out_r, 32'd12);
    check("single_z", 32'(out_z), 32'd0);
    check("single_op", 32'(out_op), 32'd1);
    check("single_alu_idle", 32'(alu_op), 32'd0);
    tick();
    check("single_drained", 32'(out_valid), 32'd0);

    // zero flag: 9 - 9
    drive(1'b1, 3'b101, 32'd9, 32'd9);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    check("zero_r", out_r, 32'd0);
    check("zero_z", 32'(out_z), 32'd1);
    check("zero_op", 32'(out_op), 32'd5);
    tick();

    // backpressure: five adds, results 11,22,33,44,55
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'b001, 32'(i * 10), 32'(i));
      check($sformatf("bp_ready_%0d", i), 32'(in_ready), 32'd1);
      tick();
    end
    drive(1'b1, 3'b001, 32'd60, 32'd6);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    check("bp_full_count", 32'(count), 32'd4);
    check("bp_held_r", out_r, 32'd11);
    tick();
    check("bp_hold_r", out_r, 32'd11);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_count", 32'(count), 32'd4);

    // push and pop at full: no bypass, push lands a cycle later
    out_ready = 1'b1;
    check("full_pop_ready", 32'(in_ready), 32'd0);
    tick();
    check("full_pop_r", out_r, 32'd22);
    check("full_pop_count", 32'(count), 32'd3);
    check("full_pop_ready_after", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("pushpop_r", out_r, 32'd33);
    check("pushpop_count", 32'(count), 32'd3);
    for (int i = 4; i <= 6; i++) begin
      tick();
      check($sformatf("drain_r_%0d", i), out_r, 32'(i * 11));
      check($sformatf("drain_valid_%0d", i), 32'(out_valid), 32'd1);
    end
    check("drain_empty", 32'(count), 32'd0);
    tick();
    check("drain_done", 32'(out_valid), 32'd0);

    // reset mid-stream with count=3 and a held result
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 3'b100, 32'(i), 32'hFF);
      tick();
    end
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    check("mid_count", 32'(count), 32'd3);
    check("mid_valid", 32'(out_valid), 32'd1);
    check("mid_r", out_r, 32'hFE);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("post_rst_valid_%0d", i), 32'(out_valid), 32'd0);
      check($sformatf("post_rst_count_%0d", i), 32'(count), 32'd0);
    end
    check("post_rst_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 3'b011, 32'h0F, 32'hF0);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    check("post_rst_r", out_r, 32'hFF);
    check("post_rst_op", 32'(out_op), 32'd3);
    tick();

`ifdef ALU_FEEDER_ILLEGAL_FILTER_EN
    check("filt_err_init", 32'(err_cnt), 32'd0);
    drive(1'b1, 3'b111, 32'd1, 32'd1);
    check("filt_ready", 32'(in_ready), 32'd1);
    tick();
    check("filt_err", 32'(err_cnt), 32'd1);
    check("filt_count", 32'(count), 32'd0);
    drive(1'b1, 3'b010, 32'hF0, 32'h3C);
    tick();
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    tick();
    check("filt_r", out_r, 32'h30);
    check("filt_op", 32'(out_op), 32'd2);
    tick();
    check("filt_single", 32'(out_valid), 32'd0);
    check("filt_err_final", 32'(err_cnt), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_feeder.md
ALU_FEEDER -- requirements
Module: alu_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the command FIFO depth in entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the command handshake; transfer when both are high at a clk edge.
REQ-005 SHALL have ports in_op (input, 3), in_a (input, 32) and in_b (input, 32): command opcode and operands.
REQ-006 SHALL have ports alu_op (output, 3), alu_a (output, 32) and alu_b (output, 32), driven to the downstream combinational ALU.
REQ-007 SHALL have ports alu_r (input, 32) and alu_z (input, 1): ALU result and zero flag.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-009 SHALL have ports out_r (output, 32), out_z (output, 1) and out_op (output, 3): registered result, zero flag and the opcode that produced them.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits, the current FIFO occupancy.

Function
REQ-011 SHALL assert in_ready iff count < DEPTH, with no same-cycle bypass when the FIFO is full.
REQ-012 SHALL drive alu_op/alu_a/alu_b from the FIFO head entry when count > 0, and all-zero otherwise.
REQ-013 SHALL pop the head and load alu_r/alu_z/alu_op into out_r/out_z/out_op, setting out_valid, at a clk edge when count > 0 and (out_valid == 0 or out_ready == 1).
REQ-014 SHALL clear out_valid at a clk edge when out_valid && out_ready and no pop occurs in the same cycle.
REQ-015 SHALL hold out_r/out_z/out_op/out_valid stable while out_valid && !out_ready.
REQ-016 SHALL handle a push and a pop in the same cycle with count unchanged; a pop is allowed even when the FIFO is full.
REQ-017 SHALL give a latency of exactly one clk edge from command acceptance to out_valid when the FIFO is empty and the output register is free or draining.
REQ-018 SHALL preserve command order; results leave in acceptance order.
REQ-019 SHALL implement read/write pointers that wrap modulo DEPTH without gaps.
REQ-020 SHALL sustain a throughput of one result per cycle while in_valid and out_ready are held high.

Reset
REQ-021 SHALL, while rst_n is low, hold count=0, out_valid=0, out_r=0, out_z=0, out_op=0, both pointers at 0 and in_ready=0.
REQ-022 SHALL raise in_ready on the first clk edge after rst_n deasserts.
REQ-023 SHALL discard all queued commands and the held result when reset is asserted mid-operation; nothing is replayed.

Configuration
REQ-024 SHALL, with macro ALU_FEEDER_ILLEGAL_FILTER_EN defined, accept but not enqueue commands with in_op of 3'b000 or 3'b111, and increment a 16-bit saturating output err_cnt (reset 0) for each such command.
REQ-025 SHALL, without ALU_FEEDER_ILLEGAL_FILTER_EN, enqueue every opcode unchanged and omit the err_cnt port.

Verification
REQ-026 Single op: after reset, push op=001, a=5, b=7 with out_ready=1 -> next edge out_valid=1, out_r=12, out_z=0, out_op=001.
REQ-027 Backpressure: out_ready=0, push 5 commands (DEPTH=4) -> first 4 accepted, 1 held in output register, in_ready=0 on the 6th; raise out_ready -> results drain in order, one per cycle.
REQ-028 Zero flag: push op=101, a=9, b=9 -> out_r=0, out_z=1.
REQ-029 Simultaneous push/pop at full: count=4, in_valid=1, out_ready=1 -> in_ready=0 that cycle, count goes to 3 after the pop, then the push lands next cycle.
REQ-030 Reset mid-stream: with count=3, pulse rst_n low between edges -> count=0 and out_valid=0 immediately; no stale results appear after release.
REQ-031 Filter (macro defined): push op=111, then op=010 with a=0xF0, b=0x3C -> err_cnt=1, single result out_r=0x30.
